// File: rtl/sequence_collector.sv
// Collects NUM_INPUTS serial values via a TRIGGER/VALID_IN handshake and
// presents them as one parallel vector; enforces a trigger-low gap and an optional response timeout.
module sequence_collector #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        START,
  output logic                        TRIGGER,
  input  logic [WIDTH-1:0]            VALUE_IN,
  input  logic                        VALID_IN,
  output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
  output logic                        VALID_OUT,
  output logic                        ERROR,
  output logic                        BUSY
);

  localparam int unsigned VW  = NUM_INPUTS * WIDTH;
  localparam int unsigned IW  = $clog2(NUM_INPUTS);
  localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam int unsigned TMO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TMO_EN     = (TIMEOUT != 0);

  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_INPUTS - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TOW-1:0] TMO_LAST = TOW'(TMO_LAST_I);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic [GW-1:0]  gap_q,   gap_d;
  logic [TOW-1:0] tmo_q,   tmo_d;
  logic [VW-1:0]  stage_q, stage_d;
  logic [VW-1:0]  values_q, values_d;
  logic           trig_q,  trig_d;
  logic           vout_q,  vout_d;
  logic           err_q,   err_d;
  logic           busy_q,  busy_d;

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
      stage_q  <= '0;
      values_q <= '0;
      trig_q   <= 1'b0;
      vout_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      stage_q  <= stage_d;
      values_q <= values_d;
      trig_q   <= trig_d;
      vout_q   <= vout_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    stage_d  = stage_q;
    values_d = values_q;
    trig_d   = trig_q;
    vout_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          idx_d   = '0;
          tmo_d   = '0;
          trig_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        // A response arriving on the timeout cycle still wins
        if (VALID_IN) begin
          stage_d[idx_q*WIDTH +: WIDTH] = VALUE_IN;
          trig_d  = 1'b0;
          gap_d   = '0;
          state_d = S_LOW;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          trig_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TOW'(1);
        end
      end
      S_LOW: begin
        // The final gap is completed too so the sequencer sees the last fall
        if (gap_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            values_d = stage_q;
            vout_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            tmo_d   = '0;
            trig_d  = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        trig_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign TRIGGER    = trig_q;
  assign VALUES_OUT = values_q;
  assign VALID_OUT  = vout_q;
  assign ERROR      = err_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sequence_collector.sv
// Scoreboard bench for sequence_collector: directed responder stimulus, with a
// separate monitor that checks every VALID_OUT / ERROR pulse against queued expectations.
module tb_sequence_collector;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] vec;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  value = 8'h00;
  logic        sel = 1'b0;

  logic        trig_a, vout_a, err_a, busy_a;
  logic        trig_b, vout_b, err_b, busy_b;
  logic [31:0] vals_a, vals_b;

  logic        trig_o, vout_o, err_o, busy_o;
  logic [31:0] vals_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic [31:0] last_vec = 32'h0;

  always #5 CLK = ~CLK;

  sequence_collector #(.NUM_INPUTS(N), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .START(start & ~sel), .TRIGGER(trig_a),
    .VALUE_IN(value), .VALID_IN(valid & ~sel), .VALUES_OUT(vals_a),
    .VALID_OUT(vout_a), .ERROR(err_a), .BUSY(busy_a)
  );

  sequence_collector #(.NUM_INPUTS(N), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(0)) u_dut_notmo (
    .CLK(CLK), .RSTN(RSTN), .START(start & sel), .TRIGGER(trig_b),
    .VALUE_IN(value), .VALID_IN(valid & sel), .VALUES_OUT(vals_b),
    .VALID_OUT(vout_b), .ERROR(err_b), .BUSY(busy_b)
  );

  assign trig_o = sel ? trig_b : trig_a;
  assign vout_o = sel ? vout_b : vout_a;
  assign err_o  = sel ? err_b  : err_a;
  assign busy_o = sel ? busy_b : busy_a;
  assign vals_o = sel ? vals_b : vals_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge CLK) begin
    if (RSTN && (vout_o || err_o)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid_out=%0b error=%0b values=0x%08h", vout_o, err_o, vals_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({err_o, vout_o, vals_o} !== {e.err, ~e.err, e.vec}) begin
          errors++;
          $display("FAIL scoreboard: got err=%0b vout=%0b values=0x%08h expected err=%0b vout=%0b values=0x%08h",
                   err_o, vout_o, vals_o, e.err, ~e.err, e.vec);
        end
      end
    end
  end

  // Full collection: each value returned dly cycles after its TRIGGER rise
  task automatic run_collect(input logic [31:0] vec, input int dly, input bit spur);
    int n;
    exp_t e;
    e.err = 1'b0;
    e.vec = vec;
    sb_q.push_back(e);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    check("trigger_after_start", 32'(trig_o), 32'd1);
    check("busy_after_start", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (dly) next_cycle();
      check("trigger_high_at_response", 32'(trig_o), 32'd1);
      valid = 1'b1;
      value = vec[i*8 +: 8];
      next_cycle();
      valid = 1'b0;
      value = 8'h00;
      n = 0;
      while (trig_o == 1'b0 && vout_o == 1'b0 && n < 50) begin
        if (spur && n == 1) begin
          valid = 1'b1;
          value = 8'hEE;
          start = 1'b1;
        end else begin
          valid = 1'b0;
          start = 1'b0;
        end
        n++;
        next_cycle();
      end
      valid = 1'b0;
      start = 1'b0;
      check("trigger_low_gap", 32'(n), 32'(GAP));
    end
    check("valid_out_at_end", 32'(vout_o), 32'd1);
    check("busy_clear_at_end", 32'(busy_o), 32'd0);
    if (!sel) last_vec = vec;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;

    repeat (3) next_cycle();
    check("reset_trigger", 32'(trig_o), 32'd0);
    check("reset_valid_out", 32'(vout_o), 32'd0);
    check("reset_error", 32'(err_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_values", vals_o, 32'h0);
    RSTN = 1'b1;
    next_cycle();

    // Minimum-latency loopback and a slower responder
    run_collect(32'h44332211, 1, 1'b0);
    next_cycle();
    run_collect(32'hD4C3B2A1, 3, 1'b0);
    next_cycle();

    // No response: timeout abort keeps the previous vector
    e.err = 1'b1;
    e.vec = last_vec;
    sb_q.push_back(e);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    n = 0;
    while (trig_o == 1'b1 && n < 100) begin
      n++;
      next_cycle();
    end
    check("timeout_trigger_high_cycles", 32'(n), 32'(TMO));
    check("timeout_error_pulse", 32'(err_o), 32'd1);
    check("timeout_busy_clear", 32'(busy_o), 32'd0);
    next_cycle();
    check("timeout_error_one_cycle", 32'(err_o), 32'd0);
    run_collect(32'h5A6B7C8D, 2, 1'b0);
    next_cycle();

    // Response on the very cycle the timeout would expire
    run_collect(32'h13579BDF, int'(TMO) - 1, 1'b0);
    next_cycle();

    // Spurious VALID_IN in IDLE is ignored
    valid = 1'b1;
    value = 8'hEE;
    repeat (3) next_cycle();
    valid = 1'b0;
    value = 8'h00;
    next_cycle();
    check("idle_spurious_values", vals_o, last_vec);
    check("idle_spurious_busy", 32'(busy_o), 32'd0);

    // Spurious VALID_IN and START during the gaps
    run_collect(32'hCAFE1234, 1, 1'b1);
    next_cycle();
    check("no_queued_start", 32'(busy_o), 32'd0);

    // Reset mid-collection after two values
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      valid = 1'b1;
      value = 8'h99;
      next_cycle();
      valid = 1'b0;
      repeat (GAP) next_cycle();
    end
    RSTN = 1'b0;
    next_cycle();
    RSTN = 1'b1;
    check("midreset_trigger", 32'(trig_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_values", vals_o, 32'h0);
    last_vec = 32'h0;
    next_cycle();
    run_collect(32'h04030201, 1, 1'b0);
    next_cycle();

    // TIMEOUT disabled: TRIGGER held 100 cycles per value
    sel = 1'b1;
    next_cycle();
    run_collect(32'h87654321, 99, 1'b0);
    next_cycle();
    sel = 1'b0;
    next_cycle();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_collector.md
# sequence_collector

Initiator/receiver counterpart of the value sequencer: drives the TRIGGER handshake toward a sequencer, captures one WIDTH-bit value per trigger pulse, and reassembles NUM_INPUTS values into a parallel vector. It sits at the consuming end of a serial value link, for example between a layer's serialized outputs and the next block's parallel inputs. It adds a programmable trigger-low gap so the sequencer's edge detection sees every fall, and it adds a response timeout.

## Interface
- NUM_INPUTS, 4: values per vector; must be ≥ 2.
- WIDTH, 8: bits per value.
- GAP_CYCLES, 4: cycles TRIGGER is held low between pulses; must be ≥ 1.
- TIMEOUT, 16: maximum cycles TRIGGER stays high waiting for VALID_IN; 0 disables the timeout.
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- START  in  1  begin a collection; sampled only in IDLE.
- TRIGGER  out  1  request strobe to the sequencer; registered.
- VALUE_IN  in  WIDTH  value from the sequencer; sampled when VALID_IN=1.
- VALID_IN  in  1  VALUE_IN qualifier; single-cycle pulse per request.
- VALUES_OUT  out  NUM_INPUTS*WIDTH  assembled vector; value k occupies bits [k*WIDTH +: WIDTH].
- VALID_OUT  out  1  one-cycle pulse when VALUES_OUT is updated.
- ERROR  out  1  one-cycle pulse on timeout abort.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values: TRIGGER=0, VALID_OUT=0, ERROR=0, BUSY=0, VALUES_OUT=0. Internal index, staging register, gap counter and timeout counter are all cleared.
- Internal state: index idx, width $clog2(NUM_INPUTS); staging register; gap counter; timeout counter.
- **IDLE**, TRIGGER=0:
  - START=1 → idx←0, TRIGGER←1, timeout counter←0, go to TRIG_HIGH.
  - VALID_IN is ignored.
- **TRIG_HIGH**, TRIGGER=1:
  - VALID_IN=1 → staging[idx*WIDTH +: WIDTH]←VALUE_IN, TRIGGER←0, gap counter←0, go to TRIG_LOW.
  - Otherwise, if TIMEOUT≠0 and the timeout counter equals TIMEOUT-1 → TRIGGER←0, ERROR←1 for one cycle, go to IDLE. VALUES_OUT is unchanged and VALID_OUT is not asserted.
  - Otherwise the timeout counter increments.
  - If VALID_IN and the timeout condition occur in the same cycle, VALID_IN wins: the value is captured and ERROR is not raised.
- **TRIG_LOW**, TRIGGER=0, gap counter increments each cycle. When the gap counter equals GAP_CYCLES-1:
  - If idx < NUM_INPUTS-1 → idx←idx+1, TRIGGER←1, timeout counter←0, go to TRIG_HIGH.
  - If idx = NUM_INPUTS-1 → VALUES_OUT←staging (including the value just captured), VALID_OUT←1, go to IDLE.
  - VALID_IN is ignored.
- START while BUSY=1 is ignored and does not queue.
- Staging slots are overwritten only by accepted values; stale slots from an aborted run never reach VALUES_OUT, because every slot is rewritten before completion.
- RSTN low in any state returns every register to its reset value on that edge; any in-flight collection is discarded.

## Timing
- START sampled high at edge n → TRIGGER=1 from cycle n+1. BUSY=1 from n+1.
- VALID_IN sampled at edge t in TRIG_HIGH → TRIGGER=0 from t+1.
- TRIGGER stays low for exactly GAP_CYCLES cycles, then rises at t+1+GAP_CYCLES. For the last value, VALID_OUT=1 instead, in cycle t+1+GAP_CYCLES.
- The final gap is always completed before VALID_OUT, so the sequencer observes the last fall and returns to its idle state.
- VALID_OUT and ERROR are each high for exactly one cycle. BUSY is already 0 in that cycle, and a START in that cycle is accepted.
- Timeout: TRIGGER is high for exactly TIMEOUT cycles. ERROR is high in the cycle after the last high cycle, and TRIGGER is 0 in that same cycle.
- Minimum collection length from START to VALID_OUT, with VALID_IN arriving one cycle after each TRIGGER rise: NUM_INPUTS*(2+GAP_CYCLES) cycles.
- VALUES_OUT holds its value until the next successful completion.

## Test plan
- Loopback against the sequencer loaded with 0x44332211, all defaults, pulse START → four TRIGGER pulses, VALUES_OUT=0x44332211, one VALID_OUT pulse, ERROR never asserted.
- Responder model returns 0xA1, 0xB2, 0xC3, 0xD4, each 3 cycles after a TRIGGER rise → VALUES_OUT=0xD4C3B2A1. Each TRIGGER-low gap is exactly 4 cycles. VALID_OUT appears 1+4 cycles after the 4th VALID_IN.
- No VALID_IN after START, TIMEOUT=16 → TRIGGER high exactly 16 cycles, one ERROR pulse, VALUES_OUT keeps its previous value, BUSY=0 afterwards. On the next START a full collection succeeds.
- VALID_IN asserted in the same cycle as timeout expiry → value captured, no ERROR.
  - Spurious VALID_IN during TRIG_LOW and IDLE → ignored, with VALUES_OUT bits unchanged.
  - START pulsed while BUSY → ignored.
- RSTN asserted after 2 of 4 values → next cycle TRIGGER=0, BUSY=0, VALUES_OUT=0. A fresh START with values 0x01..0x04 yields 0x04030201.
- TIMEOUT=0 with the responder delaying 100 cycles → TRIGGER held high for 100 cycles, no ERROR, correct vector assembled.
